sha256_sched_ctrl: RTL and testbench
====================================

# sha256_sched_ctrl

Round sequencer and message-schedule engine for the SHA-256 core. It accepts one 512-bit block as sixteen 32-bit words and holds them in a 16-entry circular buffer. It then issues 64 compression rounds, presenting W_t, K_t and t to the compression datapath each round. The block sits between the block-input interface and the compression round logic, and signals block completion so the datapath can perform its final hash addition.

## Interface
- No parameters. Round count (64) and buffer depth (16) are fixed by the algorithm.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to process a new block; accepted only when `ready`=1.
- `ready` out 1: idle, can accept `start`.
- `msg_valid` in 1: `msg_word` carries the next message word.
- `msg_word` in 32: message word, big-endian word order, W0 first.
- `msg_ready` out 1: controller accepts a word this cycle.
- `round_stall` in 1: datapath back-pressure; holds the current round.
- `round_en` out 1: `wt`/`kt`/`round_idx` are valid for a round this cycle.
- `round_idx` out 6: current round t, 0..63.
- `wt` out 32: W_t.
- `kt` out 32: K_t.
- `done` out 1: single-cycle pulse after round 63 retires.

## Operation
- States: IDLE, LOAD, ROUND, FINISH.
- **IDLE**
  - `ready`=1.
  - `start`=1 moves to LOAD and clears the word counter and t.
- **LOAD**
  - `msg_ready`=1.
  - Each cycle with `msg_valid`=1 writes `msg_word` into buf[cnt] and increments cnt.
  - `msg_valid`=0 idles without timeout.
  - The 16th accepted word moves to ROUND with t=0.
- **ROUND**
  - `round_en`=1.
  - For t<16, `wt` = buf[t].
  - For t≥16, `wt` = σ1(buf[(t−2)%16]) + buf[(t−7)%16] + σ0(buf[(t−15)%16]) + buf[t%16], all mod 2^32.
    - σ0 = ROTR7^ROTR18^SHR3.
    - σ1 = ROTR17^ROTR19^SHR10.
  - A round retires when `round_en`=1 and `round_stall`=0. On retirement:
    - when t≥16, `wt` is written into buf[t%16];
    - t increments.
  - `round_stall`=1 freezes t, the buffer, `wt`, `kt` and `round_idx`, and keeps `round_en`=1.
  - Retirement at t=63 moves to FINISH.
- **FINISH**
  - `done`=1 for one cycle, then IDLE.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `msg_valid` outside LOAD is ignored, and no buffer write occurs.
  - `round_stall` outside ROUND is ignored.
- **Output decoding**
  - `ready`, `msg_ready`, `round_en` and `done` are Moore decodes of the state.
  - `wt`, `kt` and `round_idx` are combinational from t and the buffer, and are don't-care when `round_en`=0.

## Timing
- **Reset values**
  - State IDLE, t=0, cnt=0, buffer cleared to 0.
  - `ready`=1; `msg_ready`=0; `round_en`=0; `done`=0; `round_idx`=0.
- **Reset mid-operation**
  - Asserting `rst_n`=0 in any state returns to IDLE immediately.
  - No `done` is emitted for the aborted block, and the partial block is discarded.
- **Latency from `start` accepted at cycle 0, no stalls, words back-to-back**
  - LOAD in cycles 1–16.
  - ROUND in cycles 17–80 (t=0..63).
  - `done` in cycle 81.
  - `ready` again in cycle 82.
- **Stalls and gaps**
  - Each stalled cycle adds one cycle.
  - Each `msg_valid`=0 cycle in LOAD adds one cycle.
- **Throughput:** 82 cycles per block minimum; `start` may be asserted in cycle 82.
- **Word-counter wrap:** cnt wraps 15→0 only on the LOAD→ROUND transition, so no 17th write is possible.
- **Round-counter wrap:** t saturates at 63 and is cleared on entry to LOAD.

## Structure
- **Shared package `sha256_pkg`:**
  - state encoding constants;
  - the 64-entry K constant array;
  - round count 64 and buffer depth 16 localparams.
- **Sub-module `sha256_k_rom`:** combinational 6-bit address to 32-bit K_t lookup.
- **Function modules:** σ0/σ1 reuse the existing `sigma0_func_schedule` / `sigma1_func_schedule` modules, and the adds use `adder_32bit` instances.

## Test plan
- **Reset:** after reset release → `ready`=1, `msg_ready`=0, `round_en`=0, `done`=0.
- **"abc" block, load phase:** start, then load W0=0x61626380, W1..W14=0, W15=0x00000018, no stalls.
  - t=0: `wt`=0x61626380, `kt`=0x428a2f98.
  - t=16: `wt`=0x61626380.
  - t=17: `wt`=0x000F0000.
- **"abc" block, completion:**
  - t=63: `kt`=0xc67178f2.
  - `done` in cycle 81, `ready` in cycle 82.
- **Stall:** hold `round_stall`=1 for 3 cycles at t=20.
  - `round_idx`=20 and `wt` are stable across the stall.
  - `done` arrives 3 cycles late (cycle 84).
- **Gapped load:** insert 2 `msg_valid`=0 gaps during LOAD → 18 LOAD cycles; identical W sequence.
- **Abort and misuse:**
  - Pulse `rst_n` low at t=40 → IDLE, no `done`.
  - A subsequent block completes correctly.
  - A `start` issued during ROUND is ignored.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared FSM encoding, round/buffer sizes and the SHA-256 K constant table
package sha256_pkg;
  localparam int ROUNDS = 64;
  localparam int DEPTH = 16;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINISH} state_e;
  localparam logic [31:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/adder_32bit.sv
// adder_32bit: modulo-2^32 adder; a_i/b_i operands, sum_o result
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: round constant lookup; addr_i round index, k_o K_t
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr_i,
  output logic [31:0] k_o
);
  assign k_o = K[addr_i];
endmodule

// File: rtl/sigma0_func_schedule.sv
// sigma0_func_schedule: schedule sigma0 (ROTR7^ROTR18^SHR3); x_i word in, y_o result
module sigma0_func_schedule (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[6:0], x_i[31:7]} ^ {x_i[17:0], x_i[31:18]} ^ (x_i >> 3);
endmodule

// File: rtl/sigma1_func_schedule.sv
// sigma1_func_schedule: schedule sigma1 (ROTR17^ROTR19^SHR10); x_i word in, y_o result
module sigma1_func_schedule (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ (x_i >> 10);
endmodule

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: loads 16 message words, issues 64 rounds of W_t/K_t/t with stall, pulses done; ports: start/ready, msg_valid/msg_word/msg_ready, round_stall/round_en/round_idx/wt/kt, done
module sha256_sched_ctrl
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        ready,
  input  logic        msg_valid,
  input  logic [31:0] msg_word,
  output logic        msg_ready,
  input  logic        round_stall,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic [31:0] wt,
  output logic [31:0] kt,
  output logic        done
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] t_q, t_d;
  logic [31:0] buf_q [DEPTH];
  logic load_wr, retire, accept;
  logic [3:0] i2, i7, i15;
  logic [31:0] s0, s1, a0, a1, w_exp;
  assign accept = state_q == S_IDLE && start;
  assign load_wr = state_q == S_LOAD && msg_valid;
  assign retire = round_en && !round_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = load_wr && cnt_q == 4'd15 ? S_ROUND : S_LOAD;
      S_ROUND:  state_d = retire && t_q == 6'd63 ? S_FINISH : S_ROUND;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ready = state_q == S_IDLE;
    msg_ready = state_q == S_LOAD;
    round_en = state_q == S_ROUND;
    done = state_q == S_FINISH;
  end
  assign cnt_d = accept ? 4'd0 : load_wr ? cnt_q + 4'd1 : cnt_q;
  assign t_d = accept ? 6'd0 : retire && t_q != 6'd63 ? t_q + 6'd1 : t_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      t_q <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      t_q <= t_d;
      if (load_wr) buf_q[cnt_q] <= msg_word;
      else if (retire && t_q[5:4] != 2'd0) buf_q[t_q[3:0]] <= wt;
    end
  // buffer slot t%16 still holds W_{t-16}; the -15 tap is the slot after it
  assign i2 = t_q[3:0] - 4'd2;
  assign i7 = t_q[3:0] - 4'd7;
  assign i15 = t_q[3:0] + 4'd1;
  sigma0_func_schedule u_s0 (.x_i(buf_q[i15]), .y_o(s0));
  sigma1_func_schedule u_s1 (.x_i(buf_q[i2]), .y_o(s1));
  adder_32bit u_add0 (.a_i(s1), .b_i(buf_q[i7]), .sum_o(a0));
  adder_32bit u_add1 (.a_i(s0), .b_i(buf_q[t_q[3:0]]), .sum_o(a1));
  adder_32bit u_add2 (.a_i(a0), .b_i(a1), .sum_o(w_exp));
  assign wt = t_q[5:4] == 2'd0 ? buf_q[t_q[3:0]] : w_exp;
  assign round_idx = t_q;
  sha256_k_rom u_rom (.addr_i(t_q), .k_o(kt));
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: checks the schedule controller against a full-array SHA-256 expansion model
module tb_sha256_sched_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, msg_valid = 1'b0, round_stall = 1'b0;
  logic [31:0] msg_word = '0;
  logic ready, msg_ready, round_en, done;
  logic [5:0] round_idx;
  logic [31:0] wt, kt;
  logic [31:0] blk [16];
  logic [31:0] wm [64];
  logic [31:0] km [64];
  logic [31:0] tr_wt [64];
  logic [31:0] tr_kt [64];
  int n_chk = 0, n_err = 0;
  typedef struct { int t; logic [31:0] wt; logic [31:0] kt; bit has_wt; } vec_t;
  vec_t vecs [4];
  sha256_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .msg_valid(msg_valid),
    .msg_word(msg_word), .msg_ready(msg_ready), .round_stall(round_stall), .round_en(round_en),
    .round_idx(round_idx), .wt(wt), .kt(kt), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  // K_t = first 32 fractional bits of cbrt(prime_t) = low word of floor(cbrt(p * 2^96))
  function automatic logic [31:0] kcalc(input int p);
    logic [127:0] tgt, lo, hi, mid;
    tgt = 128'(p) << 96;
    lo = '0;
    hi = 128'(1) << 36;
    while (lo < hi) begin
      mid = (lo + hi + 128'd1) >> 1;
      if (mid * mid * mid <= tgt) lo = mid;
      else hi = mid - 128'd1;
    end
    return lo[31:0];
  endfunction
  task automatic expand();
    for (int t = 0; t < 64; t++)
      wm[t] = t < 16 ? blk[t] :
        (rotr(wm[t-2], 17) ^ rotr(wm[t-2], 19) ^ (wm[t-2] >> 10)) + wm[t-7] +
        (rotr(wm[t-15], 7) ^ rotr(wm[t-15], 18) ^ (wm[t-15] >> 3)) + wm[t-16];
  endtask
  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask
  task automatic load_rand();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask
  task automatic run_block(input logic [31:0] gap_mask, input int gap_pct, input int stall_t,
                           input int stall_n, input int stall_pct, input int abort_t,
                           input bit misuse, output int load_cyc);
    int words, retired, gaps, stalls, cyc, st_here, ph;
    bit prev_stall, stall, gap;
    logic [31:0] p_wt, p_kt;
    logic [5:0] p_idx;
    expand();
    words = 0; retired = 0; gaps = 0; stalls = 0; st_here = 0; load_cyc = 0;
    prev_stall = 0; p_wt = '0; p_kt = '0; p_idx = '0;
    chk("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    step();
    cyc = 1;
    forever begin
      if (cyc > 400) begin
        n_chk++; n_err++;
        $display("FAIL timeout actual=cycle %0d required=done by 400", cyc);
        break;
      end
      ph = words < 16 ? 1 : retired < 64 ? 2 : 3;
      chk("ready_busy", 32'(ready), 32'd0);
      chk("msg_ready", 32'(msg_ready), 32'(ph == 1));
      chk("round_en", 32'(round_en), 32'(ph == 2));
      chk("done", 32'(done), 32'(ph == 3));
      start = misuse && ph != 3 && $urandom_range(1) == 1;
      msg_valid = 1'b0;
      round_stall = 1'b0;
      msg_word = $urandom;
      if (ph == 1) begin
        gap = gap_mask[load_cyc % 32] || int'($urandom_range(99)) < gap_pct;
        msg_valid = !gap;
        if (!gap) msg_word = blk[words];
        else gaps++;
        round_stall = misuse && $urandom_range(1) == 1;
        load_cyc++;
      end else if (ph == 2) begin
        if (retired == abort_t) begin
          start = 1'b0; msg_valid = 1'b0;
          rst_n = 1'b0;
          #1;
          chk("abort_ready", 32'(ready), 32'd1);
          chk("abort_round_en", 32'(round_en), 32'd0);
          chk("abort_msg_ready", 32'(msg_ready), 32'd0);
          chk("abort_idx", 32'(round_idx), 32'd0);
          @(posedge clk);
          #3 rst_n = 1'b1;
          for (int i = 0; i < 90; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
          end
          chk("abort_idle", 32'(ready), 32'd1);
          return;
        end
        if (prev_stall) begin
          chk("stall_idx", 32'(round_idx), 32'(p_idx));
          chk("stall_wt", wt, p_wt);
          chk("stall_kt", kt, p_kt);
        end
        stall = (retired == stall_t && st_here < stall_n) || int'($urandom_range(99)) < stall_pct;
        if (stall) begin
          stalls++;
          if (retired == stall_t) st_here++;
        end else begin
          chk("round_idx", 32'(round_idx), 32'(retired));
          chk("wt", wt, wm[retired]);
          chk("kt", kt, km[retired]);
          tr_wt[retired] = wt;
          tr_kt[retired] = kt;
        end
        p_idx = round_idx; p_wt = wt; p_kt = kt;
        prev_stall = stall;
        round_stall = stall;
        msg_valid = misuse && $urandom_range(1) == 1;
      end else begin
        chk("done_cycle", 32'(cyc), 32'(81 + gaps + stalls));
        msg_valid = misuse && $urandom_range(1) == 1;
        step();
        start = 1'b0; msg_valid = 1'b0;
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("done_single", 32'(done), 32'd0);
        break;
      end
      step();
      if (ph == 1 && msg_valid) words++;
      if (ph == 2 && !round_stall) retired++;
      cyc++;
    end
    start = 1'b0; msg_valid = 1'b0; round_stall = 1'b0;
  endtask
  initial begin
    int p, nk, lc;
    bit prime;
    p = 2; nk = 0;
    while (nk < 64) begin
      prime = 1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 0;
      if (prime) begin km[nk] = kcalc(p); nk++; end
      p++;
    end
    vecs[0] = '{t: 0,  wt: 32'h61626380, kt: 32'h428a2f98, has_wt: 1};
    vecs[1] = '{t: 16, wt: 32'h61626380, kt: 32'he49b69c1, has_wt: 1};
    vecs[2] = '{t: 17, wt: 32'h000F0000, kt: 32'hefbe4786, has_wt: 1};
    vecs[3] = '{t: 63, wt: 32'h0,        kt: 32'hc67178f2, has_wt: 0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_msg_ready", 32'(msg_ready), 32'd0);
    chk("reset_round_en", 32'(round_en), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_round_idx", 32'(round_idx), 32'd0);
    step();
    load_abc();
    run_block(32'h0, 0, -1, 0, 0, -1, 0, lc);
    chk("abc_load_cycles", 32'(lc), 32'd16);
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].has_wt) chk($sformatf("abc_wt_t%0d", vecs[i].t), tr_wt[vecs[i].t], vecs[i].wt);
      chk($sformatf("abc_kt_t%0d", vecs[i].t), tr_kt[vecs[i].t], vecs[i].kt);
    end
    run_block(32'h0, 0, 20, 3, 0, -1, 0, lc);
    run_block(32'h0000_0208, 0, -1, 0, 0, -1, 0, lc);
    chk("gapped_load_cycles", 32'(lc), 32'd18);
    for (int i = 0; i < 4; i++)
      if (vecs[i].has_wt) chk($sformatf("gapped_wt_t%0d", vecs[i].t), tr_wt[vecs[i].t], vecs[i].wt);
    load_rand();
    run_block(32'h0, 0, -1, 0, 0, 40, 1, lc);
    load_abc();
    run_block(32'h0, 0, -1, 0, 0, -1, 1, lc);
    for (int b = 0; b < 5; b++) begin
      load_rand();
      run_block(32'h0, 20, -1, 0, 15, -1, 1, lc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
